// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD accelerator: FSM state encoding and the
// default operand width used by gcd_engine and gcd_datapath.
package gcd_pkg;

  localparam int GCD_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } gcd_state_e;

endpackage : gcd_pkg

// File: rtl/gcd_datapath.sv
// Operand registers, magnitude comparator, subtractor and result select for
// the GCD engine. The controller drives load_i (capture new operands) and
// step_i (perform one subtraction); the larger operand is always the
// minuend, so the subtraction never wraps.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_o,
  output logic             a_zero_o,
  output logic             b_zero_o,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_d;
  logic             lt_s;
  logic             gt_s;

  // Comparator: relations between the two working operands.
  always_comb begin
    lt_s     = (a_q < b_q);
    gt_s     = (a_q > b_q);
    eq_o     = (a_q == b_q);
    a_zero_o = (a_q == {WIDTH{1'b0}});
    b_zero_o = (b_q == {WIDTH{1'b0}});
  end

  // Next operand values: capture on load, otherwise subtract the smaller
  // operand from the larger one when a step is requested.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load_i) begin
      a_d = a_i;
      b_d = b_i;
    end else if (step_i && gt_s) begin
      a_d = a_q - b_q;
    end else if (step_i && lt_s) begin
      b_d = b_q - a_q;
    end else begin
      a_d = a_q;
      b_d = b_q;
    end
  end

  // Result select: a zero A means B is the answer; otherwise A is (B==0 or A==B).
  always_comb begin
    if (a_zero_o) begin
      result_o = b_q;
    end else begin
      result_o = a_q;
    end
  end

  // Operand registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q <= {WIDTH{1'b0}};
      b_q <= {WIDTH{1'b0}};
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

endmodule : gcd_datapath

// File: rtl/gcd_engine.sv
// GCD accelerator top: start/done handshake, IDLE/CALC/DONE controller,
// held result register and the gcd_datapath instance.
// Optional iteration counter: define GCD_ITER_CNT_EN to add the iter_cnt
// port, a saturating count of subtraction cycles of the last calculation.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEFAULT
`ifdef GCD_ITER_CNT_EN
  ,
  parameter int CNT_W = WIDTH
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out
`ifdef GCD_ITER_CNT_EN
  ,
  output logic [CNT_W-1:0] iter_cnt
`endif
);

  gcd_state_e       state_q;
  gcd_state_e       state_d;
  logic [WIDTH-1:0] gcd_q;
  logic [WIDTH-1:0] gcd_d;
  logic             load_s;
  logic             step_s;
  logic             eq_s;
  logic             a_zero_s;
  logic             b_zero_s;
  logic             finish_s;
  logic [WIDTH-1:0] result_s;

  gcd_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (load_s),
    .step_i   (step_s),
    .a_i      (a_in),
    .b_i      (b_in),
    .eq_o     (eq_s),
    .a_zero_o (a_zero_s),
    .b_zero_o (b_zero_s),
    .result_o (result_s)
  );

  // The calculation terminates once either operand is zero or both match.
  always_comb begin
    finish_s = a_zero_s | b_zero_s | eq_s;
  end

  // Controller: next state, datapath strobes and result update.
  always_comb begin
    state_d = state_q;
    gcd_d   = gcd_q;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          gcd_d   = {WIDTH{1'b0}};
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (finish_s) begin
          gcd_d   = result_s;
          state_d = ST_DONE;
        end else begin
          step_s  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and held-result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gcd_q   <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      gcd_q   <= gcd_d;
    end
  end

  // Status outputs decoded purely from the state register.
  always_comb begin
    ready   = (state_q == ST_IDLE);
    busy    = (state_q == ST_CALC) || (state_q == ST_DONE);
    done    = (state_q == ST_DONE);
    gcd_out = gcd_q;
  end

`ifdef GCD_ITER_CNT_EN
  logic [CNT_W-1:0] iter_q;
  logic [CNT_W-1:0] iter_d;

  // Iteration counter: cleared on accept, counts subtraction cycles, sticks at all-ones.
  always_comb begin
    iter_d = iter_q;
    if (load_s) begin
      iter_d = {CNT_W{1'b0}};
    end else if (step_s && (iter_q != {CNT_W{1'b1}})) begin
      iter_d = iter_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      iter_d = iter_q;
    end
  end

  // Iteration counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_q <= {CNT_W{1'b0}};
    end else begin
      iter_q <= iter_d;
    end
  end

  // Counter output straight from its register.
  always_comb begin
    iter_cnt = iter_q;
  end
`endif

endmodule : gcd_engine

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine (default WIDTH=16). Expected results
// come from a Euclid-by-division reference model: the GCD is the last
// non-zero remainder and the subtraction count is the sum of the quotients
// minus one (the final quotient step ends on equality, not on zero).
module tb_gcd_engine;
  import gcd_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         abort = 1'b0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] gcd_out;
`ifdef GCD_ITER_CNT_EN
  logic [W-1:0] iter_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  gcd_engine #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .abort   (abort),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .gcd_out (gcd_out)
`ifdef GCD_ITER_CNT_EN
    ,
    .iter_cnt(iter_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: Euclid with division, subtraction count from the quotients.
  task automatic ref_gcd(input int unsigned a, input int unsigned b,
                         output int unsigned g, output int unsigned k);
    int unsigned x, y, t, s;
    if (a == 0) begin
      g = b; k = 0;
    end else if (b == 0) begin
      g = a; k = 0;
    end else begin
      x = a; y = b; s = 0;
      while (y != 0) begin
        s += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      g = x;
      k = s - 1;
    end
  endtask

  // One full transaction from IDLE. noise: hold a competing start(5,5)
  // during CALC. abrt: assert abort together with the accepting start.
  task automatic run_op(input int unsigned a, input int unsigned b,
                        input bit noise, input bit abrt, input string tag);
    int unsigned g, k, cyc, busy_n;
    ref_gcd(a, b, g, k);
    start = 1'b1; a_in = W'(a); b_in = W'(b); abort = abrt;
    tick();
    abort = 1'b0;
    if (noise) begin
      start = 1'b1; a_in = W'(5); b_in = W'(5);
    end else begin
      start = 1'b0;
    end
    chk({tag, "_accept_busy"}, busy, 1);
    chk({tag, "_accept_clr"}, gcd_out, 0);
    cyc = 1;
    busy_n = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && cyc < k + 10) begin
      tick();
      cyc++;
      if (busy === 1'b1) busy_n++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, cyc, k + 2);
    chk({tag, "_gcd"}, gcd_out, g);
    chk({tag, "_busy_cycles"}, busy_n, k + 2);
`ifdef GCD_ITER_CNT_EN
    chk({tag, "_iter"}, iter_cnt, k);
`endif
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_ready_after"}, ready, 1);
    chk({tag, "_held"}, gcd_out, g);
  endtask

  initial begin
    bit seen_done;
    int unsigned ra, rb;

    // Reset state
    #3;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_gcd", gcd_out, 0);
    tick();
    rst = 1'b0;
    tick();

    // Directed cases
    run_op(12, 18, 1'b0, 1'b0, "g12_18");
    run_op(0, 7, 1'b0, 1'b0, "g0_7");
    run_op(0, 0, 1'b0, 1'b0, "g0_0");
    run_op(7, 0, 1'b0, 1'b0, "g7_0");

    // Start while busy is ignored, then accepted afterwards
    run_op(48, 18, 1'b1, 1'b0, "g48_18_noise");
    run_op(5, 5, 1'b0, 1'b0, "g5_5");

    // Abort on CALC cycle 2
    start = 1'b1; a_in = W'(100); b_in = W'(75);
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_gcd", gcd_out, 0);
    seen_done = (done === 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("abort_no_done", seen_done, 0);

    // Abort in IDLE is ignored
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    chk("idle_abort_ready", ready, 1);
    chk("idle_abort_busy", busy, 0);

    // Start and abort together in IDLE: start wins
    run_op(20, 8, 1'b0, 1'b1, "g20_8_abrt");

    // Asynchronous reset in the middle of CALC
    start = 1'b1; a_in = W'(200); b_in = W'(3);
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ready", ready, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_gcd", gcd_out, 0);
    #3;
    rst = 1'b0;
    tick();
    run_op(9, 6, 1'b0, 1'b0, "g9_6");

    // Randomized operands (kept small to bound run time)
    for (int i = 0; i < 30; i++) begin
      ra = $urandom_range(0, 63);
      rb = $urandom_range(0, 63);
      run_op(ra, rb, 1'b0, 1'b0, "rand");
    end

    // Longest case: 65534 subtractions, no wrap, no counter saturation
    run_op(1, 65535, 1'b0, 1'b0, "g1_65535");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gcd_engine
